// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Optional overflow output is enabled by defining BIN_TO_BCD_OVF_CHECK_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
`ifdef BIN_TO_BCD_OVF_CHECK_EN
    ,
    output logic                  overflow
`endif
);

    localparam int SW    = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [BIN_W-1:0]   sr_reg;
    logic [SW-1:0]      scratch_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic [SW-1:0]      bcd_reg;
    logic [SW-1:0]      adj;
    logic [SW:0]        shift_full;
    logic               accept;
    logic               last;

    // Each digit >= 5 gets +3 in 4-bit arithmetic; max result is 12, so no carry out.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                  ? scratch_reg[gi*4 +: 4] + 4'd3
                                  : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    // Bit SW is what falls out of the top digit; it is dropped from the result.
    assign shift_full = {adj, sr_reg[BIN_W-1]};

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == CNT_W'(BIN_W - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg      <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            bcd_reg     <= '0;
        end else begin
            done_reg <= last;
            if (accept) begin
                sr_reg      <= bin;
                scratch_reg <= '0;
                cnt_reg     <= '0;
            end else if (state_reg == SHIFT) begin
                sr_reg      <= sr_reg << 1;
                scratch_reg <= shift_full[SW-1:0];
                cnt_reg     <= cnt_reg + CNT_W'(1);
                if (last) begin
                    bcd_reg <= shift_full[SW-1:0];
                end
            end
        end
    end

`ifdef BIN_TO_BCD_OVF_CHECK_EN
    logic ovf_acc_reg;
    logic ovf_reg;

    // Sticky across one conversion; published only on the done edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_acc_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (accept) begin
            ovf_acc_reg <= 1'b0;
        end else if (state_reg == SHIFT) begin
            ovf_acc_reg <= ovf_acc_reg | shift_full[SW];
            if (last) begin
                ovf_reg <= ovf_acc_reg | shift_full[SW];
            end
        end
    end

    assign overflow = ovf_reg;
`else
    logic unused_spill;
    assign unused_spill = shift_full[SW];
`endif

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [BIN_W-1:0]  bin = '0;
    logic              busy;
    logic              done;
    logic [19:0]       bcd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef BIN_TO_BCD_OVF_CHECK_EN
    logic overflow;
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    logic        start2 = 1'b0;
    logic [9:0]  bin2 = '0;
    logic        busy2;
    logic        done2;
    logic [11:0] bcd2;
    logic        overflow2;
    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
    );
`else
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );
`endif

    // Reference: result is the decimal digits of (value mod 10^DIGITS).
    function automatic logic [19:0] to_bcd(input longint v);
        logic [19:0] r;
        longint x;
        x = v % 100000;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: one accepted value yields a result BIN_W edges later.
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_ovf;
    logic [19:0] m_bcd;
    int          m_edges;
    longint      m_val;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_bcd   <= '0;
            m_ovf   <= 1'b0;
            m_edges <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy  <= 1'b1;
                m_val   <= longint'(bin);
                m_edges <= 1;
            end
        end else begin
            if (m_edges == BIN_W) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_bcd  <= to_bcd(m_val);
                m_ovf  <= (m_val >= 100000);
            end else begin
                m_edges <= m_edges + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy_model", 32'(busy), 32'(m_busy));
            check("done_model", 32'(done), 32'(m_done));
            check("bcd_model", 32'(bcd), 32'(m_bcd));
`ifdef BIN_TO_BCD_OVF_CHECK_EN
            check("ovf_model", 32'(overflow), 32'(m_ovf));
`endif
        end
    end

    // Drive start for one accepting edge; returns at edge+1.
    task automatic start_conv(input logic [BIN_W-1:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done (bounded); check result literal and, if exp_n >= 0, the edge count.
    task automatic wait_done(input string name, input logic [19:0] exp, input int exp_n);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_bcd"}, 32'(bcd), 32'(exp));
            if (exp_n >= 0) check({name, "_latency"}, n, exp_n);
        end
        $display("conv %s: bcd=%h edges=%0d", name, bcd, n);
    endtask

    initial begin
        // Reset with start held: must not be accepted until rst falls.
        start = 1'b1;
        bin   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("zero_busy_edge1", 32'(busy), 32'd1);
        wait_done("zero", 20'h00000, BIN_W);
        check("zero_busy_after", 32'(busy), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        start_conv(16'd65535);
        wait_done("max", 20'h65535, BIN_W);
`ifdef BIN_TO_BCD_OVF_CHECK_EN
        check("max_ovf", 32'(overflow), 32'd0);
`endif
        start_conv(16'd1234);
        wait_done("v1234", 20'h01234, BIN_W);

        // Back-to-back: second start issued in the done cycle.
        repeat (3) @(posedge clk);
        #1;
        start_conv(16'd9);
        wait_done("b2b_9", 20'h00009, BIN_W);
        start_conv(16'd10);
        wait_done("b2b_10", 20'h00010, BIN_W);
        start = 1'b0;

        // Start and bin toggled mid-conversion are ignored.
        repeat (2) @(posedge clk);
        #1;
        start_conv(16'd4321);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 16'd999;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 16'd7;
        wait_done("mid", 20'h04321, BIN_W - 4);
        repeat (20) @(posedge clk);
        #1;

        // Abort at edge 8 with reset.
        start_conv(16'd5555);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        start_conv(16'd42);
        wait_done("after_abort", 20'h00042, BIN_W);

        // Values exercising high digits and the 5..9 adjust paths.
        start_conv(16'd59999);
        wait_done("v59999", 20'h59999, BIN_W);
        start_conv(16'd50505);
        wait_done("v50505", 20'h50505, BIN_W);

`ifdef BIN_TO_BCD_OVF_CHECK_EN
        begin
            logic [9:0]  vals [2];
            logic [11:0] exps [2];
            logic        ovfs [2];
            vals[0] = 10'd1023; exps[0] = 12'h023; ovfs[0] = 1'b1;
            vals[1] = 10'd999;  exps[1] = 12'h999; ovfs[1] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                bit seen2;
                seen2 = 0;
                start2 = 1'b1;
                bin2   = vals[k];
                @(posedge clk);
                #1;
                start2 = 1'b0;
                for (int i = 0; i < 40 && !seen2; i++) begin
                    @(posedge clk);
                    #1;
                    if (done2) seen2 = 1;
                end
                check("w10_done_seen", 32'(seen2), 32'd1);
                check("w10_bcd", 32'(bcd2), 32'(exps[k]));
                check("w10_ovf", 32'(overflow2), 32'(ovfs[k]));
                $display("conv w10: bin=%0d bcd=%h ovf=%0b", vals[k], bcd2, overflow2);
            end
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16, which sets the binary input width in bits (legal range 1 or more).
REQ-002 The block SHALL have parameter DIGITS, default 5, which sets the number of BCD output digits (legal range 1 or more).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bin, input, BIN_W bits: unsigned binary value, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new result on bcd.
REQ-009 The block SHALL have port bcd, output, DIGITS*4 bits: packed BCD result, digit d at bits [4d+3:4d], digit 0 least significant.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and SHIFT, and SHALL use the shift-add-3 (double-dabble) algorithm, processing one input bit per clock.
REQ-011 In IDLE with start=1, the block SHALL, on that edge, capture bin into a BIN_W shift register, clear the DIGITS*4 scratch register, clear the bit counter, set busy=1 and enter SHIFT.
REQ-012 On each SHIFT edge, the block SHALL first add 3 to every scratch digit of value 5 or more, then shift {scratch, shift register} left by 1 with the shift-register MSB entering scratch bit 0, then increment the counter.
REQ-013 The block SHALL discard the bit shifted out of the top scratch digit, so that bcd equals bin mod 10^DIGITS.
REQ-014 On the edge performing the BIN_W-th shift, the block SHALL load bcd with the final scratch value, set done=1, set busy=0 and return to IDLE.
REQ-015 Latency SHALL be fixed at BIN_W+1 rising edges from the start-accepting edge (counted as edge 1) to the edge that raises done.
REQ-016 done SHALL be high for exactly one cycle per conversion.
REQ-017 bcd SHALL hold its value between done pulses and SHALL never show intermediate scratch values.
REQ-018 The block SHALL ignore start while busy=1, and changes on bin after capture SHALL have no effect on the result.
REQ-019 Start high in the cycle done is high SHALL be accepted, since the FSM is in IDLE, allowing back-to-back conversions every BIN_W+1 cycles.
REQ-020 Digit adjust SHALL use 4-bit arithmetic only; an adjusted digit never exceeds 12 before the shift.

Reset
REQ-021 When rst=1 on a rising edge, the block SHALL set state=IDLE, busy=0, done=0, bcd=0, clear the counter and scratch register, and clear overflow when present.
REQ-022 Reset SHALL take priority over start and over an in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-023 A start held high during reset SHALL NOT be accepted until the first edge with rst=0.

Configuration
REQ-024 When macro BIN_TO_BCD_OVF_CHECK_EN is defined, the block SHALL add output port overflow, 1 bit.
REQ-025 With the macro defined, overflow SHALL be a sticky-per-conversion flag: set if any shift moves a 1 out of the top scratch digit, cleared on the start-accepting edge, and loaded into the output on the done edge.
REQ-026 With the macro defined, overflow SHALL be valid together with done and held until the next done or reset.
REQ-027 Without the macro, the overflow port and its logic SHALL be absent; truncation per REQ-013 SHALL be silent.

Verification
REQ-028 Defaults: after reset, start with bin=16'd0 -> done on edge 17 with bcd=20'h00000, busy high for edges 1 through 16.
REQ-029 Defaults: bin=16'd65535 -> bcd=20'h65535; bin=16'd1234 -> bcd=20'h01234; overflow=0 if the macro is defined.
REQ-030 The bench SHALL run back-to-back starts with values 9 then 10 (start re-asserted in the done cycle) -> bcd=20'h00009, then 17 cycles later bcd=20'h00010, each done exactly one cycle wide.
REQ-031 Pulsing start and changing bin mid-conversion (bin=4321 accepted, then start with bin=999 at edge 5) -> result 20'h04321 and no extra done.
REQ-032 Asserting rst at edge 8 of a conversion -> busy=0, bcd=0, no done pulse; a following start with bin=42 -> bcd=20'h00042.
REQ-033 With BIN_W=10, DIGITS=3 and the macro defined, bin=1023 -> bcd=12'h023 and overflow=1; bin=999 -> bcd=12'h999 and overflow=0.
